btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
- Sequences every write into the branch target buffer. Sits between the EX-stage control-flow resolution signals and the BTB write port.
- Runs a full-table invalidation sweep after reset and on each flush request (fence.i / context change).
- Holds taken-branch updates that arrive during a sweep in a small coalescing queue, then drains it afterwards.
- The predict/read side of the BTB is untouched; this block owns the write port exclusively.

Parameters:
- TABLE_ENTRIES, 64: number of BTB entries; power of two, at least 4.
- INDEX_WIDTH, $clog2(TABLE_ENTRIES): index field, taken from pc bits [2 +: INDEX_WIDTH].
- TAG_WIDTH, 30-INDEX_WIDTH: tag field, taken from pc bits [31 -: TAG_WIDTH].
- QUEUE_DEPTH, 4: pending-update queue depth; power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cflow_valid  in  1  EX holds a resolved control-flow instruction.
- cflow_taken  in  1  that instruction was taken.
- pc_e  in  32  PC of the EX instruction.
- cflow_target  in  32  resolved target.
- flush_req  in  1  single-cycle request to invalidate the whole BTB.
- wr_en  out  1  BTB write strobe.
- wr_index  out  INDEX_WIDTH  BTB write index.
- wr_entry  out  btb_entry_t  {valid, tag, target} written to the BTB.
- busy  out  1  sweep in progress.
- flush_done  out  1  one-cycle pulse when a sweep completes.
- drop_cnt  out  16  count of updates lost to a full queue; saturates.

Behaviour:
- All outputs are registered.
- Reset values: wr_en=0, wr_index=0, wr_entry='0, busy=1, flush_done=0, drop_cnt=0. Queue is emptied; the FSM enters SWEEP with cnt=0.
- Update event: cflow_valid && cflow_taken. It produces the entry {1, pc_e[31 -: TAG_WIDTH], cflow_target} at index pc_e[2 +: INDEX_WIDTH].
- FSM has two states, SWEEP and IDLE.
- SWEEP:
  - Each cycle, one write of wr_entry='0 at wr_index=cnt; cnt increments.
  - The write with cnt=TABLE_ENTRIES-1 is the last one. The next cycle goes to IDLE with busy=0 and flush_done=1 for exactly one cycle.
  - A sweep therefore produces exactly TABLE_ENTRIES consecutive wr_en cycles.
- Flush timing: flush_req in cycle N gives the first sweep write in cycle N+1. busy is 1 during cycles N+1 to N+TABLE_ENTRIES.
- After reset: the first sweep write is in the first cycle after reset deasserts.
- Update events during SWEEP are enqueued and never written mid-sweep.
- IDLE write selection:
  - Queue non-empty: the head is written next cycle (latency 1) and dequeued.
  - Queue empty: an update event in cycle N is bypassed directly to wr_en/wr_index/wr_entry in cycle N+1, one per cycle.
  - Update event while the queue is non-empty: it is enqueued in the same cycle the head dequeues (simultaneous enq/deq allowed).
- Coalescing: an enqueue whose index equals the tail entry's index overwrites the tail instead of allocating a slot. This applies only when the tail is not also being dequeued that cycle.
- Queue full, non-coalescing event, no dequeue that cycle: the event is dropped and drop_cnt increments, saturating at 16'hFFFF.
- wr_en is 0 in IDLE cycles with no write.
- flush_req in IDLE, cycle N:
  - Queue is cleared; an update event in the same cycle is discarded (not counted as dropped).
  - A bypass or queue write scheduled for N+1 is suppressed; the sweep write of index 0 takes N+1.
- flush_req during SWEEP: cnt restarts at 0 next cycle and the queue is cleared. Still exactly one flush_done, at the end of the restarted sweep.
- reset at any point (mid-sweep, queue full) overrides everything and restarts the post-reset sweep.
- Queue pointers are QUEUE_DEPTH-wide modulo with an extra wrap bit; full/empty are derived from pointer compare.

Decomposition:
- btb_entry_t, TABLE_ENTRIES, INDEX_WIDTH and TAG_WIDTH live in riscv_defines. This block reads the widths from the package.
- The ctrl_state_t enum {IDLE, SWEEP} is added to riscv_defines.
- Sub-module btb_update_queue: FIFO with tail-coalesce, full/empty, and clear.
- The FSM, sweep counter, write mux and drop counter stay in btb_update_ctrl.

Test Plan:
- Reset 3 cycles, then release -> wr_en high for 64 consecutive cycles with wr_index 0..63, wr_entry=0; flush_done pulses the following cycle; busy then 0.
- IDLE, update pc_e=0x0000_1008, target=0x0000_2000 at cycle N -> cycle N+1: wr_en=1, wr_index=2, wr_entry={1, tag of 0x1008, 0x2000}.
- During a sweep, send 6 updates with indices 1,1,2,3,4,5 -> the two index-1 updates coalesce (second target kept). Queue holds 1,2,3,4; index 5 is dropped, so drop_cnt=1. After flush_done, 4 writes in order, one per cycle.
- IDLE with 2 entries queued, flush_req plus an update in the same cycle -> no queued or new update is ever written; 64 sweep writes start the next cycle; drop_cnt unchanged.
- flush_req at sweep cnt=40 -> next write index 0; 64 further writes follow; exactly one flush_done in total.
- Assert reset while the queue is full mid-sweep -> outputs return to reset values; the queue is empty afterwards and a fresh 64-write sweep runs.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared core definitions: BTB geometry, the BTB entry layout and the BTB
// write-controller state encoding.
package riscv_defines;

    localparam int TABLE_ENTRIES = 64;
    localparam int INDEX_WIDTH   = $clog2(TABLE_ENTRIES);
    localparam int TAG_WIDTH     = 30 - INDEX_WIDTH;
    localparam int QUEUE_DEPTH   = 4;
    localparam int QPTR_WIDTH    = $clog2(QUEUE_DEPTH) + 1;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/btb_update_ctrl_if.sv
// EX resolution inputs and BTB write-port outputs of the BTB update controller.
interface btb_update_ctrl_if;
    import riscv_defines::*;

    logic                   cflow_valid;
    logic                   cflow_taken;
    logic [31:0]            pc_e;
    logic [31:0]            cflow_target;
    logic                   flush_req;
    logic                   wr_en;
    logic [INDEX_WIDTH-1:0] wr_index;
    btb_entry_t             wr_entry;
    logic                   busy;
    logic                   flush_done;
    logic [15:0]            drop_cnt;

    modport master (
        output cflow_valid, cflow_taken, pc_e, cflow_target, flush_req,
        input  wr_en, wr_index, wr_entry, busy, flush_done, drop_cnt
    );

    modport slave (
        input  cflow_valid, cflow_taken, pc_e, cflow_target, flush_req,
        output wr_en, wr_index, wr_entry, busy, flush_done, drop_cnt
    );

endinterface

// File: rtl/btb_update_queue.sv
// Pending BTB update FIFO. A push that hits the tail index rewrites the tail
// in place; clear empties it immediately.
module btb_update_queue
    import riscv_defines::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   enq,
    input  logic [INDEX_WIDTH-1:0] enq_idx,
    input  btb_entry_t             enq_entry,
    input  logic                   deq,
    output logic [INDEX_WIDTH-1:0] head_idx,
    output btb_entry_t             head_entry,
    output logic                   empty,
    output logic                   drop
);
    localparam int AW = QPTR_WIDTH - 1;

    logic [QPTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_ptr;
    logic [INDEX_WIDTH-1:0] idx_q [QUEUE_DEPTH];
    logic [INDEX_WIDTH-1:0] idx_d [QUEUE_DEPTH];
    btb_entry_t             ent_q [QUEUE_DEPTH];
    btb_entry_t             ent_d [QUEUE_DEPTH];
    logic                   full, tail_alone, coalesce, alloc;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tail_ptr   = wr_ptr_q - QPTR_WIDTH'(1);
    assign tail_alone = ((wr_ptr_q - rd_ptr_q) == QPTR_WIDTH'(1));
    assign head_idx   = idx_q[rd_ptr_q[AW-1:0]];
    assign head_entry = ent_q[rd_ptr_q[AW-1:0]];

    // A tail that is leaving this cycle cannot absorb the new update.
    assign coalesce = enq && !empty && (idx_q[tail_ptr[AW-1:0]] == enq_idx) &&
                      !(deq && tail_alone);
    assign alloc    = enq && !coalesce && (!full || deq);
    assign drop     = enq && !coalesce && full && !deq && !clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        ent_d    = ent_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (coalesce)
                ent_d[tail_ptr[AW-1:0]] = enq_entry;
            if (alloc) begin
                idx_d[wr_ptr_q[AW-1:0]] = enq_idx;
                ent_d[wr_ptr_q[AW-1:0]] = enq_entry;
                wr_ptr_d = wr_ptr_q + QPTR_WIDTH'(1);
            end
            if (deq)
                rd_ptr_d = rd_ptr_q + QPTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
        ent_q <= ent_d;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Owns the BTB write port: invalidation sweeps after reset/flush, and taken
// branch updates either bypassed directly or drained from the pending queue.
module btb_update_ctrl
    import riscv_defines::*;
(
    input  logic             clk,
    input  logic             reset,
    btb_update_ctrl_if.slave bus
);
    ctrl_state_t            state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d, sweep_idx;
    logic                   last_q, last_d;
    logic                   wr_en_q, wr_en_d;
    logic [INDEX_WIDTH-1:0] wr_index_q, wr_index_d;
    btb_entry_t             wr_entry_q, wr_entry_d;
    logic                   busy_q, busy_d;
    logic                   flush_done_q, flush_done_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic                   upd_ev, in_sweep, sweep_wr, bypass;
    logic                   q_enq, q_deq, q_empty, q_drop;
    logic [INDEX_WIDTH-1:0] upd_idx, q_head_idx;
    btb_entry_t             upd_entry, q_head_entry;
    logic                   unused_pc_lsbs;

    assign upd_ev         = bus.cflow_valid && bus.cflow_taken;
    assign upd_idx        = bus.pc_e[2 +: INDEX_WIDTH];
    assign upd_entry      = '{valid: 1'b1, tag: bus.pc_e[31 -: TAG_WIDTH], target: bus.cflow_target};
    assign unused_pc_lsbs = ^bus.pc_e[1:0];

    // last_q marks the cycle after the final sweep write; the FSM stays in
    // SWEEP through it so flush_done lands in the first IDLE cycle.
    assign in_sweep  = (state_q == SWEEP);
    assign sweep_wr  = bus.flush_req || (in_sweep && !last_q);
    assign sweep_idx = bus.flush_req ? '0 : cnt_q;

    assign q_enq  = upd_ev && !bus.flush_req && (in_sweep || !q_empty);
    assign q_deq  = !in_sweep && !bus.flush_req && !q_empty;
    assign bypass = upd_ev && !bus.flush_req && !in_sweep && q_empty;

    btb_update_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .clr        (bus.flush_req),
        .enq        (q_enq),
        .enq_idx    (upd_idx),
        .enq_entry  (upd_entry),
        .deq        (q_deq),
        .head_idx   (q_head_idx),
        .head_entry (q_head_entry),
        .empty      (q_empty),
        .drop       (q_drop)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = 1'b0;
        wr_en_d      = 1'b0;
        wr_index_d   = '0;
        wr_entry_d   = '0;
        busy_d       = 1'b0;
        flush_done_d = 1'b0;
        if (sweep_wr) begin
            wr_en_d    = 1'b1;
            wr_index_d = sweep_idx;
            busy_d     = 1'b1;
            cnt_d      = sweep_idx + INDEX_WIDTH'(1);
            state_d    = SWEEP;
            last_d     = (sweep_idx == '1);
        end else if (in_sweep) begin
            state_d      = IDLE;
            flush_done_d = 1'b1;
        end else if (q_deq) begin
            wr_en_d    = 1'b1;
            wr_index_d = q_head_idx;
            wr_entry_d = q_head_entry;
        end else if (bypass) begin
            wr_en_d    = 1'b1;
            wr_index_d = upd_idx;
            wr_entry_d = upd_entry;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (q_drop && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SWEEP;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_index_q   <= '0;
            wr_entry_q   <= '0;
            busy_q       <= 1'b1;
            flush_done_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            wr_en_q      <= wr_en_d;
            wr_index_q   <= wr_index_d;
            wr_entry_q   <= wr_entry_d;
            busy_q       <= busy_d;
            flush_done_q <= flush_done_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_index   = wr_index_q;
    assign bus.wr_entry   = wr_entry_q;
    assign bus.busy       = busy_q;
    assign bus.flush_done = flush_done_q;
    assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: reset sweep, bypass, coalesce/drop,
// flush in IDLE and mid-sweep, and reset with a full queue.
module tb_btb_update_ctrl;
    import riscv_defines::*;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    btb_update_ctrl_if bus();

    btb_update_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Update vectors: {pc, target}; index = pc[7:2], tag = pc[31:8].
    logic [31:0] tab_pc  [13];
    logic [31:0] tab_tgt [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] pack_out();
        return {bus.wr_en, bus.busy, bus.flush_done, bus.wr_index, bus.wr_entry};
    endfunction

    function automatic logic [56:0] ent(input logic [31:0] pc, input logic [31:0] tgt);
        return {1'b1, pc[31:8], tgt};
    endfunction

    task automatic idle_in();
        bus.cflow_valid  = 1'b0;
        bus.cflow_taken  = 1'b0;
        bus.pc_e         = '0;
        bus.cflow_target = '0;
        bus.flush_req    = 1'b0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt);
        bus.cflow_valid  = 1'b1;
        bus.cflow_taken  = 1'b1;
        bus.pc_e         = pc;
        bus.cflow_target = tgt;
    endtask

    // Checks sweep writes from..to, one per cycle, injecting inj_n updates
    // from the table in the first cycles; ends one cycle past index 'to'.
    task automatic sweep_run(input int from, input int to, input int inj_base, input int inj_n);
        for (int i = from; i <= to; i++) begin
            chk("sweep_write", pack_out(), {3'b110, 6'(i), 57'd0});
            if (i - from < inj_n) drive_upd(tab_pc[inj_base + i - from], tab_tgt[inj_base + i - from]);
            else idle_in();
            step();
        end
        idle_in();
    endtask

    initial begin
        tab_pc[0]  = 32'h0000_0104; tab_tgt[0]  = 32'h1111_0000;
        tab_pc[1]  = 32'h0000_0204; tab_tgt[1]  = 32'h2222_0000;
        tab_pc[2]  = 32'h0000_0308; tab_tgt[2]  = 32'h3333_0000;
        tab_pc[3]  = 32'h0000_040C; tab_tgt[3]  = 32'h4444_0000;
        tab_pc[4]  = 32'h0000_0510; tab_tgt[4]  = 32'h5555_0000;
        tab_pc[5]  = 32'h0000_0614; tab_tgt[5]  = 32'h6666_0000;
        tab_pc[6]  = 32'h0000_0718; tab_tgt[6]  = 32'h7777_0000;
        tab_pc[7]  = 32'h0000_081C; tab_tgt[7]  = 32'h8888_0000;
        tab_pc[8]  = 32'h0000_0A24; tab_tgt[8]  = 32'hAAAA_0000;
        tab_pc[9]  = 32'h0000_0B28; tab_tgt[9]  = 32'hBBBB_0000;
        tab_pc[10] = 32'h0000_0C2C; tab_tgt[10] = 32'hCCCC_0000;
        tab_pc[11] = 32'h0000_0D30; tab_tgt[11] = 32'hDDDD_0000;
        tab_pc[12] = 32'h0000_0E34; tab_tgt[12] = 32'hEEEE_0000;

        idle_in();
        reset = 1'b1;
        repeat (3) step();
        chk("reset_outs", pack_out(), {3'b010, 6'd0, 57'd0});
        chk("reset_drop", 66'(bus.drop_cnt), 66'd0);

        // Post-reset sweep
        reset = 1'b0;
        step();
        sweep_run(0, 63, 0, 0);
        chk("reset_sweep_done", pack_out(), {3'b001, 6'd0, 57'd0});
        step();
        chk("done_pulse_once", pack_out(), 66'd0);

        // IDLE bypass, then a not-taken branch writes nothing
        drive_upd(32'h0000_1008, 32'h0000_2000);
        step();
        idle_in();
        chk("bypass", pack_out(), {3'b100, 6'd2, 1'b1, 24'h000010, 32'h0000_2000});
        bus.cflow_valid = 1'b1;
        bus.pc_e        = 32'h0000_1008;
        step();
        idle_in();
        chk("not_taken", pack_out(), 66'd0);

        // Updates during a sweep: coalesce on index 1, drop on index 5
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        sweep_run(0, 63, 0, 6);
        chk("coal_done", pack_out(), {3'b001, 6'd0, 57'd0});
        chk("coal_drop", 66'(bus.drop_cnt), 66'd1);
        step();
        chk("drain0", pack_out(), {3'b100, 6'd1, ent(tab_pc[1], tab_tgt[1])});
        step();
        chk("drain1", pack_out(), {3'b100, 6'd2, ent(tab_pc[2], tab_tgt[2])});
        step();
        chk("drain2", pack_out(), {3'b100, 6'd3, ent(tab_pc[3], tab_tgt[3])});
        step();
        chk("drain3", pack_out(), {3'b100, 6'd4, ent(tab_pc[4], tab_tgt[4])});
        step();
        chk("drain_empty", pack_out(), 66'd0);

        // Two queued entries, then flush plus an update in the same IDLE cycle
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        sweep_run(0, 63, 6, 2);
        chk("q2_done", pack_out(), {3'b001, 6'd0, 57'd0});
        bus.flush_req = 1'b1;
        drive_upd(32'h0000_0920, 32'h9999_0000);
        step();
        idle_in();
        sweep_run(0, 63, 0, 0);
        chk("flush_idle_done", pack_out(), {3'b001, 6'd0, 57'd0});
        chk("flush_idle_drop", 66'(bus.drop_cnt), 66'd1);
        step();
        chk("flush_idle_cleared", pack_out(), 66'd0);

        // Flush while the sweep is at index 40
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        sweep_run(0, 39, 0, 0);
        chk("at_idx40", pack_out(), {3'b110, 6'd40, 57'd0});
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        sweep_run(0, 63, 0, 0);
        chk("restart_done", pack_out(), {3'b001, 6'd0, 57'd0});
        step();
        chk("restart_single_done", pack_out(), 66'd0);

        // Fill the queue mid-sweep, then reset
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        sweep_run(0, 19, 8, 5);
        chk("full_drop", 66'(bus.drop_cnt), 66'd2);
        reset = 1'b1;
        step();
        chk("midreset_outs", pack_out(), {3'b010, 6'd0, 57'd0});
        chk("midreset_drop", 66'(bus.drop_cnt), 66'd0);
        step();
        reset = 1'b0;
        step();
        sweep_run(0, 63, 0, 0);
        chk("midreset_done", pack_out(), {3'b001, 6'd0, 57'd0});
        drive_upd(32'h0000_0F38, 32'h0000_F0F0);
        step();
        idle_in();
        chk("queue_emptied", pack_out(), {3'b100, 6'd14, 1'b1, 24'h00000F, 32'h0000_F0F0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
